mdu_iterative: RTL and testbench
================================

Name: mdu_iterative

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, alongside the ALU.
- Consumes the register operands and funct3 of R-type instructions with funct7 = 0000001, which the ALU control path does not handle.
- Produces a 32-bit result after a fixed multi-cycle latency.
- Raises busy so the hazard logic stalls the pipeline while it computes.

Parameters:
- N, 32, operand/result width; iteration count equals N.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new operation; sampled only in IDLE
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  N  rs1 value
- op_b  input  N  rs2 value
- flush  input  1  abort the current operation (branch/exception squash)
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse, result valid
- result  output  N  final result; held stable until the next accepted start

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE; busy=0, done=0, result=0.
  - All internal registers cleared.
  - Reset wins over start and flush.
- States: IDLE, CALC, FIN.
- IDLE:
  - start=1 latches funct3, the operand magnitudes and the sign flags.
  - Signed views: MULH/DIV/REM take both operands signed; MULHSU takes op_a signed and op_b unsigned; all others unsigned.
  - Clears the iteration counter, goes to CALC, busy=1 next cycle.
- Special cases, detected at start (no iteration): divisor==0 or signed overflow (DIV/REM with op_a=0x80000000, op_b=0xFFFFFFFF).
  - These go directly to FIN with the result preloaded.
  - Div-by-zero: DIV/DIVU give all ones; REM/REMU give op_a.
  - Overflow: DIV gives 0x80000000; REM gives 0.
- CALC:
  - One iteration per cycle; counter 0..N-1; exits to FIN after iteration N-1.
  - Multiply: shift-add over a 2N-bit product register.
  - Divide: restoring division, one quotient bit per cycle, with an N+1-bit partial remainder.
- FIN:
  - Apply sign correction: negate the product if the operand signs differ; quotient sign is sign(a) XOR sign(b); remainder takes the sign of the dividend.
  - Select the output: MUL takes the low N bits, MULH* take the high N bits, DIV* take the quotient, REM* take the remainder.
  - Register into result; done=1 for exactly this cycle; busy=0; next state IDLE.
- Latency:
  - start sampled at edge t gives done high in cycle t+N+1 for normal ops (33 cycles for N=32).
  - Special cases give done in cycle t+1.
- start while busy=1 or done=1 is ignored; the pipeline must hold start until it sees done.
- flush=1 in any state:
  - Next state IDLE; busy=0; no done pulse; result unchanged.
  - flush with start in the same cycle: flush wins and the op is not accepted.
- Back-to-back: start is accepted in the cycle after done (the IDLE cycle).

Decomposition:
- Shared defines header gains:
  - F7_MULDIV = 7'b0000001
  - F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU, F3_DIV, F3_DIVU, F3_REM, F3_REMU
  - state encodings MDU_IDLE, MDU_CALC, MDU_FIN
- Single module.
- The N-cycle iteration datapath could be split out as mdu_core_step, but is kept inline for this size.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD (-3) -> result=0xFFFFFFEB; done exactly 33 cycles after start; busy high for 32 cycles.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) by 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 by 7 -> 14; REMU 100 by 7 -> 2.
- DIVU 0x1234 by 0 -> 0xFFFFFFFF, REM 0x1234 by 0 -> 0x1234, DIV 0x80000000 by 0xFFFFFFFF -> 0x80000000, REM same -> 0; each with done 1 cycle after start.
- flush at cycle 10 of CALC -> busy=0 next cycle, no done, result holds previous value; new MUL 3x4 started next cycle -> 12 after 33 cycles.
- rst asserted mid-CALC -> busy/done/result=0 next cycle; start asserted during busy is ignored (result of the first op unaffected).

Source files
------------

// File: rtl/mdu_iterative_pkg.sv
// Shared RV32M decode constants, FSM state encoding and signedness helpers
// for the iterative multiply/divide unit.
package mdu_iterative_pkg;

  // funct7 value selecting the M extension among R-type instructions
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // funct3 operation selects
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIN  = 2'd2
  } mdu_state_e;

  // rs1 is interpreted as signed for MULH, MULHSU, DIV and REM
  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV)  || (f3 == F3_REM);
  endfunction

  // rs2 is interpreted as signed for MULH, DIV and REM
  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Operands are converted to magnitudes at start, iterated one bit per cycle
// (shift-add multiply or restoring divide), then sign-corrected on the way
// into the result register.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           request a new operation (sampled only in IDLE)
//   funct3          operation select (MUL..REMU)
//   op_a, op_b      rs1 / rs2 values
//   flush           abort the current operation, no done pulse
//   busy            high while iterating (pipeline stall request)
//   done            one-cycle pulse, result valid
//   result          final result, held until the next completion
module mdu_iterative
  import mdu_iterative_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW = 2 * N;

  mdu_state_e    state;
  logic [2:0]    f3_q;
  logic [N-1:0]  a_mag;
  logic [N-1:0]  b_mag;
  logic          neg_q;    // negate product / quotient
  logic          neg_r;    // negate remainder
  logic [CW-1:0] cnt;
  logic [PW-1:0] prod;
  logic [N-1:0]  rem;
  logic [N-1:0]  quo;

  // start-time decode: magnitudes, signs and special-case detection
  logic          sa_c, sb_c;
  logic [N-1:0]  a_abs_c, b_abs_c;
  logic          div0_c, ovf_c, special_c;
  logic [N-1:0]  special_res_c;

  always_comb begin
    sa_c          = a_is_signed(funct3) & op_a[N-1];
    sb_c          = b_is_signed(funct3) & op_b[N-1];
    a_abs_c       = sa_c ? (~op_a + N'(1)) : op_a;
    b_abs_c       = sb_c ? (~op_b + N'(1)) : op_b;
    div0_c        = funct3[2] & (op_b == '0);
    ovf_c         = funct3[2] & ~funct3[0] &
                    (op_a == {1'b1, {(N-1){1'b0}}}) & (op_b == '1);
    special_c     = div0_c | ovf_c;
    special_res_c = '0;
    if (div0_c) begin
      // quotient of x/0 is all ones, remainder is the dividend
      special_res_c = funct3[1] ? op_a : '1;
    end else if (ovf_c) begin
      // most-negative / -1: quotient is the dividend, remainder zero
      special_res_c = funct3[1] ? '0 : op_a;
    end
  end

  // one iteration of both datapaths from the current registers
  logic [N:0]    mul_sum_c;
  logic [PW-1:0] prod_nx_c;
  logic [N:0]    part_rem_c;   // N+1-bit partial remainder
  logic          ge_c;
  logic [N-1:0]  rem_nx_c;
  logic [N-1:0]  quo_nx_c;

  always_comb begin
    mul_sum_c  = {1'b0, prod[PW-1:N]} + {1'b0, (prod[0] ? a_mag : N'(0))};
    prod_nx_c  = {mul_sum_c, prod[N-1:1]};
    part_rem_c = {rem, quo[N-1]};
    ge_c       = part_rem_c >= {1'b0, b_mag};
    rem_nx_c   = ge_c ? N'(part_rem_c - {1'b0, b_mag}) : part_rem_c[N-1:0];
    quo_nx_c   = {quo[N-2:0], ge_c};
  end

  // sign correction and output select on the final iteration's values
  logic [PW-1:0] mul_fix_c;
  logic [N-1:0]  quo_fix_c;
  logic [N-1:0]  rem_fix_c;
  logic [N-1:0]  final_res_c;

  always_comb begin
    mul_fix_c = neg_q ? (~prod_nx_c + PW'(1)) : prod_nx_c;
    quo_fix_c = neg_q ? (~quo_nx_c + N'(1)) : quo_nx_c;
    rem_fix_c = neg_r ? (~rem_nx_c + N'(1)) : rem_nx_c;
    case (f3_q)
      F3_MUL:                       final_res_c = mul_fix_c[N-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: final_res_c = mul_fix_c[PW-1:N];
      F3_DIV, F3_DIVU:              final_res_c = quo_fix_c;
      default:                      final_res_c = rem_fix_c;
    endcase
  end

  // control FSM and state registers; done is high for the whole FIN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MDU_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      f3_q   <= '0;
      a_mag  <= '0;
      b_mag  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      cnt    <= '0;
      prod   <= '0;
      rem    <= '0;
      quo    <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= MDU_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          MDU_IDLE: begin
            if (start) begin
              f3_q  <= funct3;
              a_mag <= a_abs_c;
              b_mag <= b_abs_c;
              neg_q <= sa_c ^ sb_c;
              neg_r <= sa_c;
              cnt   <= '0;
              prod  <= {N'(0), b_abs_c};
              rem   <= '0;
              quo   <= a_abs_c;
              if (special_c) begin
                result <= special_res_c;
                done   <= 1'b1;
                state  <= MDU_FIN;
              end else begin
                busy  <= 1'b1;
                state <= MDU_CALC;
              end
            end
          end
          MDU_CALC: begin
            prod <= prod_nx_c;
            rem  <= rem_nx_c;
            quo  <= quo_nx_c;
            cnt  <= cnt + CW'(1);
            if (cnt == CW'(N - 1)) begin
              result <= final_res_c;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= MDU_FIN;
            end
          end
          MDU_FIN: begin
            state <= MDU_IDLE;
          end
          default: begin
            state <= MDU_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative: expected results are queued when an op
// is launched and popped when done rises; latency and busy width checked too.
module tb_mdu_iterative;

  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   funct3;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         flush;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] sb[$];

  mdu_iterative #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // launch one op, wait for done, compare result/latency/busy width;
  // poke=1 fires a stray start mid-computation that must be ignored
  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] exp, input int lat, input bit poke);
    int n;
    int bc;
    logic [N-1:0] e;
    sb.push_back(exp);
    funct3 = f3; op_a = a; op_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    bc = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy === 1'b1) bc++;
      if (poke && n == 5) begin
        start = 1'b1; funct3 = 3'b000; op_a = 32'd5; op_b = 32'd5;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(n), 64'(lat));
    check({tag, "_busy_cycles"}, 64'(bc), 64'(lat - 1));
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    check({tag, "_result"}, 64'(result), 64'(e));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    tick();
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    tick();
    tick();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    rst = 1'b0;
    tick();

    // multiply family
    run_op("mul_7_m3",   3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0);
    run_op("mulh_min",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 0);
    run_op("mulhu_max",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0);
    run_op("mulhsu_m1",  3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, 0);

    // divide family
    run_op("div_m7_2",   3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 0);
    run_op("rem_m7_2",   3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 0);
    run_op("divu_100_7", 3'b101, 32'd100,      32'd7,        32'd14,       33, 0);
    run_op("remu_100_7", 3'b111, 32'd100,      32'd7,        32'd2,        33, 0);

    // special cases complete one cycle after start
    run_op("divu_by0",   3'b101, 32'h1234,     32'd0,        32'hFFFFFFFF, 1, 0);
    run_op("rem_by0",    3'b110, 32'h1234,     32'd0,        32'h1234,     1, 0);
    run_op("div_ovf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
    run_op("rem_ovf",    3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 0);

    // known value before the flush test
    run_op("mul_pre",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0);

    // flush at CALC cycle 10: no done, result holds
    funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_done", 64'(done), 64'd0);
    check("flush_result_hold", 64'(result), 64'hFFFFFFEB);
    run_op("mul_3_4",    3'b000, 32'd3,        32'd4,        32'd12,       33, 0);

    // flush beats a simultaneous start
    funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", 64'(busy), 64'd0);
    tick();
    check("flush_start_done", 64'(done), 64'd0);
    check("flush_start_result", 64'(result), 64'd12);

    // stray start while busy is ignored
    run_op("divu_poke",  3'b101, 32'd100,      32'd7,        32'd14,       33, 1);

    // reset mid-CALC clears outputs
    funct3 = 3'b000; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_result", 64'(result), 64'd0);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) break;
    end
    check("rst_no_late_done", 64'(done), 64'd0);
    run_op("after_rst",  3'b000, 32'd6,        32'd7,        32'd42,       33, 0);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
